// File: rtl/lcd_capture_axis_if.sv
// rtl/lcd_capture_axis_if.sv - AXI4-Stream video beat interface (tdata/tvalid/tready/tuser/tlast)
//
// Ports (signals):
//   tdata  [31:0] {8'h00, R, G, B}
//   tvalid        beat valid (master)
//   tready        beat accepted (slave)
//   tuser         first pixel of a frame
//   tlast         last pixel of a line
interface lcd_capture_axis_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/lcd_capture_axis.sv
// rtl/lcd_capture_axis.sv - LCD RGB timing capture to AXI4-Stream master with FWFT buffer
//
// Ports:
//   clk        pixel clock, single domain
//   rst_n      asynchronous active-low reset
//   cap_en     capture enable, sampled at frame boundaries only
//   err_clr    one-cycle pulse clearing ovf_flag / line_err
//   lcd_vs     vertical sync, active level VS_POL
//   lcd_en     data enable
//   lcd_rgb    pixel, R[23:16] G[15:8] B[7:0]
//   axis       stream master: tdata={8'h00,rgb}, tvalid, tready, tuser (SOF), tlast (EOL)
//   busy       state is not IDLE
//   ovf_flag   sticky: pixel dropped on full buffer
//   line_err   sticky: captured line length differed from H_ACTIVE
//   frame_cnt  frames captured without drop, wraps
module lcd_capture_axis #(
  parameter int H_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16,
  parameter bit VS_POL     = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cap_en,
  input  logic                      err_clr,
  input  logic                      lcd_vs,
  input  logic                      lcd_en,
  input  logic [23:0]               lcd_rgb,
  lcd_capture_axis_if.master        axis,
  output logic                      busy,
  output logic                      ovf_flag,
  output logic                      line_err,
  output logic [15:0]               frame_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_ACTIVE,
    S_DROP
  } state_t;

  // Input register stage
  logic        in_vs;
  logic        in_vs_d;
  logic        in_en;
  logic [23:0] in_rgb;
  logic        vs_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Park sync at its inactive level so reset release never looks like a frame edge
      in_vs   <= ~VS_POL;
      in_vs_d <= ~VS_POL;
      in_en   <= 1'b0;
      in_rgb  <= '0;
    end else begin
      in_vs   <= lcd_vs;
      in_vs_d <= in_vs;
      in_en   <= lcd_en;
      in_rgb  <= lcd_rgb;
    end
  end

  assign vs_edge = (in_vs == VS_POL) && (in_vs_d != VS_POL);

  // FSM, hold register and push control
  state_t      state, state_nx;
  logic        hold_vld, hold_vld_nx;
  logic        hold_sof, hold_sof_nx;
  logic [23:0] hold_rgb, hold_rgb_nx;
  logic [15:0] line_len, line_len_nx;
  logic        push;
  logic        push_last;
  logic        ovf_evt;
  logic        lerr_set;
  logic        frame_inc;

  // FIFO status
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          wr_en;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [25:0]   mem [FIFO_DEPTH];
  logic [25:0]   rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      hold_vld <= 1'b0;
      hold_sof <= 1'b0;
      hold_rgb <= '0;
      line_len <= '0;
    end else begin
      state    <= state_nx;
      hold_vld <= hold_vld_nx;
      hold_sof <= hold_sof_nx;
      hold_rgb <= hold_rgb_nx;
      line_len <= line_len_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    hold_vld_nx = hold_vld;
    hold_sof_nx = hold_sof;
    hold_rgb_nx = hold_rgb;
    line_len_nx = line_len;
    push        = 1'b0;
    push_last   = 1'b0;
    ovf_evt     = 1'b0;
    frame_inc   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (vs_edge && cap_en) state_nx = S_ARMED;
      end

      S_ARMED: begin
        if (vs_edge && !cap_en) begin
          state_nx = S_IDLE;
        end else if (in_en) begin
          hold_vld_nx = 1'b1;
          hold_sof_nx = 1'b1;
          hold_rgb_nx = in_rgb;
          line_len_nx = 16'd1;
          state_nx    = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        if (vs_edge) begin
          // Frame boundary: flush the pending pixel as end of line
          if (hold_vld) begin
            push      = 1'b1;
            push_last = 1'b1;
          end
          hold_vld_nx = 1'b0;
          state_nx    = cap_en ? S_ARMED : S_IDLE;
        end else if (in_en) begin
          // A following pixel proves the held one is not last in its line
          if (hold_vld) begin
            push        = 1'b1;
            line_len_nx = line_len + 16'd1;
          end else begin
            line_len_nx = 16'd1;
          end
          hold_vld_nx = 1'b1;
          hold_sof_nx = 1'b0;
          hold_rgb_nx = in_rgb;
        end else if (hold_vld) begin
          push        = 1'b1;
          push_last   = 1'b1;
          hold_vld_nx = 1'b0;
        end

        if (push && fifo_full && !pop) begin
          ovf_evt     = 1'b1;
          hold_vld_nx = 1'b0;
          if (!vs_edge) state_nx = S_DROP;
        end
        frame_inc = vs_edge && !ovf_evt;
      end

      S_DROP: begin
        if (vs_edge) state_nx = cap_en ? S_ARMED : S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // Only end-of-line pushes carry a complete line length
  assign lerr_set = push && push_last && (line_len != 16'(H_ACTIVE));

  // FWFT buffer: word = {rgb, sof, last}
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && axis.tready;
  // A pop in the same cycle frees the slot, so a full buffer can still accept
  assign wr_en      = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {hold_rgb, hold_sof, push_last};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_word     = mem[rd_ptr];
  assign axis.tvalid = !fifo_empty;
  // Mask the uninitialised RAM so outputs read zero whenever nothing is valid
  assign axis.tdata  = fifo_empty ? 32'h0 : {8'h00, rd_word[25:2]};
  assign axis.tuser  = !fifo_empty && rd_word[1];
  assign axis.tlast  = !fifo_empty && rd_word[0];

  // Status: a set in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag  <= 1'b0;
      line_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (ovf_evt)      ovf_flag <= 1'b1;
      else if (err_clr) ovf_flag <= 1'b0;
      if (lerr_set)     line_err <= 1'b1;
      else if (err_clr) line_err <= 1'b0;
      if (frame_inc)    frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_lcd_capture_axis.sv
// tb/tb_lcd_capture_axis.sv - directed table-driven bench for lcd_capture_axis
module tb_lcd_capture_axis;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cap_en = 1'b0;
  logic        err_clr = 1'b0;
  logic        lcd_vs = 1'b0;
  logic        lcd_en = 1'b0;
  logic [23:0] lcd_rgb = '0;
  logic        busy;
  logic        ovf_flag;
  logic        line_err;
  logic [15:0] frame_cnt;

  lcd_capture_axis_if axis_if ();

  lcd_capture_axis #(
    .H_ACTIVE  (8),
    .FIFO_DEPTH(16),
    .VS_POL    (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_en   (cap_en),
    .err_clr  (err_clr),
    .lcd_vs   (lcd_vs),
    .lcd_en   (lcd_en),
    .lcd_rgb  (lcd_rgb),
    .axis     (axis_if),
    .busy     (busy),
    .ovf_flag (ovf_flag),
    .line_err (line_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit rdy_toggle = 1'b0;

  logic [31:0] q_data[$];
  bit          q_user[$];
  bit          q_last[$];

  typedef struct {
    int n_lines;
    int len;
    bit cap;
    int off_at;
    bit toggle;
    int exp_beats;
    int exp_lasts;
    int exp_fc_inc;
    bit exp_lerr;
    bit exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Beat capture and stall-stability monitor
  logic [31:0] p_data;
  bit          p_valid = 1'b0;
  bit          p_ready, p_user, p_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && !p_ready) begin
        checks++;
        if (!(axis_if.tvalid && axis_if.tdata == p_data &&
              axis_if.tuser == p_user && axis_if.tlast == p_last)) begin
          failures++;
          $display("FAIL stall_stable actual=%0h/%0b required=%0h/1", axis_if.tdata, axis_if.tvalid, p_data);
        end
      end
      if (axis_if.tvalid && axis_if.tready) begin
        q_data.push_back(axis_if.tdata);
        q_user.push_back(axis_if.tuser);
        q_last.push_back(axis_if.tlast);
      end
      p_valid = axis_if.tvalid;
      p_ready = axis_if.tready;
      p_data  = axis_if.tdata;
      p_user  = axis_if.tuser;
      p_last  = axis_if.tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_toggle) axis_if.tready = ~axis_if.tready;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_user.delete();
    q_last.delete();
  endtask

  task automatic vs_pulse();
    lcd_vs = 1'b1;
    tick();
    tick();
    lcd_vs = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_line(input int tag, input int line, input int len);
    for (int p = 0; p < len; p++) begin
      lcd_en  = 1'b1;
      lcd_rgb = {8'(tag), 8'(line), 8'(p)};
      tick();
    end
    lcd_en = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic drain();
    rdy_toggle = 1'b0;
    axis_if.tready = 1'b1;
    for (int i = 0; i < 200 && axis_if.tvalid; i++) tick();
    tick();
    check("drain_empty", 32'(axis_if.tvalid), 32'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic run_row(input int r);
    logic [15:0] fc0;
    int lasts;
    int nb;
    clear_q();
    fc0 = frame_cnt;
    cap_en = vecs[r].cap;
    axis_if.tready = 1'b1;
    rdy_toggle = vecs[r].toggle;
    vs_pulse();
    for (int l = 0; l < vecs[r].n_lines; l++) begin
      if (l == vecs[r].off_at) cap_en = 1'b0;
      send_line(r, l, vecs[r].len);
    end
    vs_pulse();
    drain();
    check($sformatf("row%0d_beats", r), 32'(q_data.size()), 32'(vecs[r].exp_beats));
    lasts = 0;
    nb = (q_data.size() < vecs[r].exp_beats) ? q_data.size() : vecs[r].exp_beats;
    for (int b = 0; b < nb; b++) begin
      int ln, px;
      ln = b / vecs[r].len;
      px = b % vecs[r].len;
      if (q_last[b]) lasts++;
      check($sformatf("row%0d_data%0d", r, b), q_data[b], {8'h00, 8'(r), 8'(ln), 8'(px)});
      check($sformatf("row%0d_user%0d", r, b), 32'(q_user[b]), 32'(b == 0));
      check($sformatf("row%0d_last%0d", r, b), 32'(q_last[b]), 32'(px == vecs[r].len - 1));
    end
    check($sformatf("row%0d_lasts", r), 32'(lasts), 32'(vecs[r].exp_lasts));
    check($sformatf("row%0d_frame_cnt", r), 32'(frame_cnt), 32'(fc0 + 16'(vecs[r].exp_fc_inc)));
    check($sformatf("row%0d_line_err", r), 32'(line_err), 32'(vecs[r].exp_lerr));
    check($sformatf("row%0d_ovf", r), 32'(ovf_flag), 32'd0);
    check($sformatf("row%0d_busy", r), 32'(busy), 32'(vecs[r].exp_busy));
    pulse_clr();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] fc0;
    //          lines len cap off tog beats lasts fc lerr busy
    vecs[0] = '{4, 8, 1'b1, -1, 1'b0, 32, 4, 1, 1'b0, 1'b1};
    vecs[1] = '{4, 8, 1'b1, -1, 1'b1, 32, 4, 1, 1'b0, 1'b1};
    vecs[2] = '{2, 7, 1'b1, -1, 1'b0, 14, 2, 1, 1'b1, 1'b1};
    vecs[3] = '{4, 8, 1'b1,  2, 1'b0, 32, 4, 1, 1'b0, 1'b0};
    vecs[4] = '{3, 8, 1'b0, -1, 1'b0,  0, 0, 0, 1'b0, 1'b0};
    vecs[5] = '{1, 8, 1'b1, -1, 1'b0,  8, 1, 1, 1'b0, 1'b1};

    axis_if.tready = 1'b1;
    tick();
    tick();
    check("rst_tvalid", 32'(axis_if.tvalid), 32'd0);
    check("rst_tdata", axis_if.tdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf_flag), 32'd0);
    check("rst_line_err", 32'(line_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    for (int r = 0; r < 6; r++) run_row(r);

    // Latency: armed, empty buffer, single pixel
    lcd_en = 1'b1;
    lcd_rgb = 24'hA1B2C3;
    tick();
    lcd_en = 1'b0;
    tick();
    check("lat_k1_tvalid", 32'(axis_if.tvalid), 32'd0);
    tick();
    check("lat_k2_tvalid", 32'(axis_if.tvalid), 32'd1);
    check("lat_k2_tdata", axis_if.tdata, 32'h00A1B2C3);
    check("lat_k2_tuser", 32'(axis_if.tuser), 32'd1);
    check("lat_k2_tlast", 32'(axis_if.tlast), 32'd1);
    check("lat_line_err", 32'(line_err), 32'd1);
    pulse_clr();
    check("clr_line_err", 32'(line_err), 32'd0);

    // err_clr in the same cycle as a short-line tlast push
    for (int p = 0; p < 3; p++) begin
      lcd_en = 1'b1;
      lcd_rgb = 24'h00F000 | 24'(p);
      tick();
    end
    lcd_en = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_vs_set_line_err", 32'(line_err), 32'd1);
    pulse_clr();
    check("clr2_line_err", 32'(line_err), 32'd0);
    cap_en = 1'b1;
    vs_pulse();
    drain();

    // Backpressure overflow
    clear_q();
    fc0 = frame_cnt;
    axis_if.tready = 1'b0;
    for (int l = 0; l < 3; l++) send_line(7, l, 8);
    check("bp_tvalid", 32'(axis_if.tvalid), 32'd1);
    check("bp_head_tdata", axis_if.tdata, 32'h00070000);
    check("bp_head_tuser", 32'(axis_if.tuser), 32'd1);
    check("bp_ovf", 32'(ovf_flag), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    axis_if.tready = 1'b1;
    send_line(7, 3, 8);
    vs_pulse();
    drain();
    check("bp_beats", 32'(q_data.size()), 32'd16);
    check("bp_frame_cnt", 32'(frame_cnt), 32'(fc0));
    if (q_data.size() == 16) begin
      check("bp_beat15_tdata", q_data[15], 32'h00070107);
      check("bp_beat15_tlast", 32'(q_last[15]), 32'd1);
      check("bp_beat7_tlast", 32'(q_last[7]), 32'd1);
      check("bp_beat8_tuser", 32'(q_user[8]), 32'd0);
    end
    clear_q();
    send_line(8, 0, 8);
    vs_pulse();
    drain();
    check("bp_next_beats", 32'(q_data.size()), 32'd8);
    check("bp_next_tuser", 32'(q_user.size() > 0 ? q_user[0] : 1'b0), 32'd1);
    check("bp_next_frame_cnt", 32'(frame_cnt), 32'(fc0 + 16'd1));
    check("bp_ovf_sticky", 32'(ovf_flag), 32'd1);
    pulse_clr();
    check("bp_ovf_clr", 32'(ovf_flag), 32'd0);

    // Reset mid-line with a full buffer
    axis_if.tready = 1'b0;
    send_line(9, 0, 8);
    send_line(9, 1, 8);
    for (int p = 0; p < 3; p++) begin
      lcd_en = 1'b1;
      lcd_rgb = {8'h09, 8'h02, 8'(p)};
      tick();
    end
    check("pre_rst_ovf", 32'(ovf_flag), 32'd1);
    check("pre_rst_tvalid", 32'(axis_if.tvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(axis_if.tvalid), 32'd0);
    check("mid_rst_ovf", 32'(ovf_flag), 32'd0);
    check("mid_rst_line_err", 32'(line_err), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    lcd_en = 1'b0;
    axis_if.tready = 1'b1;
    clear_q();
    send_line(10, 0, 8);
    tick();
    check("post_rst_no_beats", 32'(q_data.size()), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    vs_pulse();
    send_line(11, 0, 8);
    vs_pulse();
    drain();
    check("post_rst_beats", 32'(q_data.size()), 32'd8);
    check("post_rst_head", q_data.size() > 0 ? q_data[0] : 32'hFFFFFFFF, 32'h000B0000);
    check("post_rst_tuser", 32'(q_user.size() > 0 ? q_user[0] : 1'b0), 32'd1);
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
